// File: rtl/fp_div_issue.sv
// fp_div_issue
// ------------
// Operand staging and issue controller placed directly in front of the fp_div
// core. Incoming dividend/divisor pairs are buffered in a small FIFO. One
// division at a time is issued with a single-cycle start pulse, and the
// operands are held steady until the core reports done. The quotient and the
// flags are then captured into a valid/ready output register. A watchdog
// bounds each operation: if the core stays silent for TIMEOUT cycles, a quiet
// NaN with the exception flag is produced and a sticky error is raised.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready        operand push handshake (in_ready = FIFO not full)
//   in_a, in_b               dividend, divisor
//   core_start               one-cycle start pulse to the core
//   core_op_a, core_op_b     registered operands, stable while in flight
//   core_done, core_res      done pulse and quotient from the core
//   core_overflow/underflow/exception  core flags, valid with core_done
//   out_valid/out_ready      result handshake
//   out_res, out_flags       quotient and {overflow, underflow, exception}
//   busy                     FIFO non-empty, operation in flight, or result held
//   timeout_err              sticky watchdog-expiry indicator
//   state_dbg                1 while an operation is in flight (FSM in WAIT)
//
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both 1. The source holds its data steady while valid=1
// and ready=0, and ready never depends on valid.
module fp_div_issue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              core_start,
  output logic [DATA_W-1:0] core_op_a,
  output logic [DATA_W-1:0] core_op_b,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_res,
  input  logic              core_overflow,
  input  logic              core_underflow,
  input  logic              core_exception,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [2:0]        out_flags,
  output logic              busy,
  output logic              timeout_err,
  output logic              state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMAX     = TW'(TIMEOUT);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
  // Quiet NaN reported when the watchdog expires.
  localparam logic [DATA_W-1:0] QNAN     = DATA_W'(32'h7FC0_0000);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_a [DEPTH];
  logic [DATA_W-1:0] fifo_b [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [TW-1:0]     timer_q;

  logic push, issue, done_ev, expire_ev;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;

  // Issue only from IDLE and only from a registered FIFO entry (no bypass).
  // The output slot must be free, or be emptied by a handshake this cycle.
  assign issue = (state_q == IDLE) && (count != '0) && (!out_valid || out_ready);

  // core_done takes priority over an expiry in the same cycle.
  assign done_ev   = (state_q == WAIT) && core_done;
  assign expire_ev = (state_q == WAIT) && !core_done && (timer_q == TMAX);

  assign busy      = (count != '0) || (state_q != IDLE) || out_valid;
  assign state_dbg = (state_q == WAIT);

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT:    if (core_done || (timer_q == TMAX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue path: operands, start pulse and watchdog timer. The timer counts
  // WAIT cycles since the start pulse and saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_start <= 1'b0;
      core_op_a  <= '0;
      core_op_b  <= '0;
      timer_q    <= '0;
    end else begin
      core_start <= issue;
      if (issue) begin
        core_op_a <= fifo_a[rd_ptr];
        core_op_b <= fifo_b[rd_ptr];
        timer_q   <= '0;
      end else if ((state_q == WAIT) && (timer_q != TMAX)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Result register. A load can never coincide with a handshake: a new
  // operation is only issued once the register is empty or being emptied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_flags   <= 3'b000;
      timeout_err <= 1'b0;
    end else if (done_ev) begin
      out_valid <= 1'b1;
      out_res   <= core_res;
      out_flags <= {core_overflow, core_underflow, core_exception};
    end else if (expire_ev) begin
      out_valid   <= 1'b1;
      out_res     <= QNAN;
      out_flags   <= 3'b001;
      timeout_err <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
